// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-organised SRAM with byte/half/word access and ERROR responses.
// Optional wait-state insertion is built when AHB_SLV_WAIT_EN is defined.
module ahb_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [31:0]   mem [MEM_DEPTH];
    logic [AW-1:0] idx_q;
    logic [3:0]    strb_q;
    logic          write_q;
    logic          hreadyout_nxt;
    logic          hresp_nxt;

    logic          final_c;
    logic          final_nxt_c;
    logic          ready_c;
    logic          adv_c;
    logic          accept_c;
    logic          legal_c;
    logic          commit_c;
    logic          fwd_c;
    logic [3:0]    strb_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   rd_word_c;
    logic          unused_c;

    assign unused_c = ^{hburst, hprot, hmastlock, htrans[0]};

`ifdef AHB_SLV_WAIT_EN
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    assign final_c     = (cnt_q >= CW'(WAIT_STATES));
    assign final_nxt_c = (cnt_nxt >= CW'(WAIT_STATES));
`else
    localparam bit ZERO_WAIT = 1'b1;
    assign final_c     = 1'b1;
    assign final_nxt_c = 1'b1;
`endif

    // Address-phase decode: lane strobes, legality and word index
    always_comb begin
        strb_c = 4'b0000;
        case (hsize)
            3'd0:    strb_c = 4'(4'b0001 << haddr[1:0]);
            3'd1:    strb_c = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    strb_c = 4'b1111;
            default: strb_c = 4'b0000;
        endcase
    end

    assign legal_c = (hsize <= 3'd2)
                   && !((hsize == 3'd1) && haddr[0])
                   && !((hsize == 3'd2) && (haddr[1:0] != 2'b00))
                   && (haddr[31:2] < 30'(MEM_DEPTH));
    assign idx_c   = haddr[AW+1:2];

    // The bus only advances out of a cycle in which this slave drives hreadyout high
    assign ready_c  = (state_q == S_IDLE) || (state_q == S_ERR2) || ((state_q == S_DATA) && final_c);
    assign adv_c    = ready_c && hready;
    assign accept_c = adv_c && hsel && htrans[1];
    assign commit_c = (state_q == S_DATA) && final_c && hready && write_q;
    assign fwd_c    = commit_c && (idx_c == idx_q);

    // Read word with the committing write merged in when both hit the same word
    always_comb begin
        rd_word_c = mem[idx_c];
        for (int b = 0; b < 4; b++) begin
            if (fwd_c && strb_q[b]) begin
                rd_word_c[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_nxt = cnt_q;
        if ((state_q == S_DATA) && !final_c) begin
            cnt_nxt = cnt_q + CW'(1);
        end
        if (accept_c) begin
            cnt_nxt = '0;
        end
`endif
        if (state_q == S_ERR1) begin
            state_nxt = S_ERR2;
        end else if (adv_c) begin
            if (accept_c) begin
                state_nxt = legal_c ? S_DATA : S_ERR1;
            end else begin
                state_nxt = S_IDLE;
            end
        end
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        hreadyout_nxt = 1'b1;
        hresp_nxt     = 1'b0;
        case (state_nxt)
            S_DATA:  hreadyout_nxt = final_nxt_c;
            S_ERR1:  begin
                hreadyout_nxt = 1'b0;
                hresp_nxt     = 1'b1;
            end
            S_ERR2:  hresp_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, response and captured address-phase registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            strb_q    <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_nxt;
            hreadyout <= hreadyout_nxt;
            hresp     <= hresp_nxt;
`ifdef AHB_SLV_WAIT_EN
            cnt_q     <= cnt_nxt;
`endif
            if (adv_c) begin
                write_q <= accept_c && legal_c && hwrite;
            end
            if (accept_c) begin
                idx_q  <= idx_c;
                strb_q <= strb_c;
            end
        end
    end

    // Read data: loaded at accept when zero-wait, else on entry to the final data cycle
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hrdata <= '0;
        end else if (accept_c && !legal_c) begin
            hrdata <= '0;
        end else if (accept_c && !hwrite && ZERO_WAIT) begin
            hrdata <= rd_word_c;
`ifdef AHB_SLV_WAIT_EN
        end else if ((state_q == S_DATA) && !write_q && !final_c
                     && (CW'(cnt_q + CW'(1)) == CW'(WAIT_STATES))) begin
            hrdata <= mem[idx_q];
`endif
        end
    end

    // Byte-masked array write at the end of the final write data cycle
    always_ff @(posedge hclk) begin
        if (!hreset && commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: vector table of single transfers plus
// back-to-back forwarding, hready stall and mid-transfer reset sequences.
module tb_ahb_slave_mem;

`ifdef AHB_SLV_WAIT_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic        hmastlock = 1'b0;
    logic        hready;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        stall = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    assign hready = hreadyout & ~stall;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(WS)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .htrans(htrans), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hready(hready), .hwdata(hwdata), .hrdata(hrdata),
        .hreadyout(hreadyout), .hresp(hresp)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic chk_rd,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic wait_ready(output int waits, output logic timeout);
        waits = 0;
        while (hreadyout !== 1'b1 && waits < 20) begin
            waits++;
            @(posedge hclk); #1;
        end
        timeout = (hreadyout !== 1'b1);
    endtask

    // One non-pipelined transfer; returns data/response seen in the data phase
    task automatic xfer(input vec_t v, output logic [31:0] rd, output logic resp_first,
                        output logic resp_last, output int waits, output logic timeout);
        hsel = 1'b1; htrans = 2'd2; haddr = v.addr; hwrite = v.wr; hsize = v.size;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = v.wdata;
        resp_first = hresp;
        wait_ready(waits, timeout);
        resp_last = hresp;
        rd = hrdata;
        @(posedge hclk); #1;
    endtask

    // Write immediately followed by a word read of raddr in the write's data phase
    task automatic b2b(input string name, input logic [2:0] wsize, input logic [31:0] waddr,
                       input logic [31:0] wdata, input logic [31:0] raddr, input logic [31:0] exp);
        int   waits;
        logic to;
        hsel = 1'b1; htrans = 2'd2; haddr = waddr; hwrite = 1'b1; hsize = wsize;
        @(posedge hclk); #1;
        hwdata = wdata; haddr = raddr; hwrite = 1'b0; hsize = 3'd2;
        wait_ready(waits, to);
        check({name, "_wr_waits"}, 32'(waits), 32'(WS));
        check({name, "_wr_timeout"}, 32'(to), 32'd0);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0;
        wait_ready(waits, to);
        check({name, "_rd_timeout"}, 32'(to), 32'd0);
        check({name, "_rdata"}, hrdata, exp);
        check({name, "_resp"}, 32'(hresp), 32'd0);
        @(posedge hclk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rf;
        logic        rl;
        int          waits;
        logic        to;

        vecs.push_back(mk(1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 32'h0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h010, 32'h0,        1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 3'd0, 32'h020, 32'hA5A5A511, 0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd0, 32'h021, 32'h5A5A225A, 0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd1, 32'h022, 32'h4433C3C3, 0, 32'h0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h020, 32'h0,        1, 32'h44332211, 0));
        vecs.push_back(mk(0, 3'd0, 32'h023, 32'h0,        1, 32'h44332211, 0));
        vecs.push_back(mk(1, 3'd2, 32'h040, 32'hAAAAAAAA, 0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd2, 32'h030, 32'h11111111, 0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd2, 32'h000, 32'h77777777, 0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd2, 32'h3FC, 32'h0BADCAFE, 0, 32'h0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h3FC, 32'h0,        1, 32'h0BADCAFE, 0));
        vecs.push_back(mk(0, 3'd2, 32'h002, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, 3'd3, 32'h010, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, 3'd2, 32'h400, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, 3'd2, 32'h012, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, 3'd1, 32'h011, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, 3'd2, 32'h010, 32'h0,        1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 3'd2, 32'h000, 32'h0,        1, 32'h77777777, 0));
        vecs.push_back(mk(0, 3'd1, 32'h022, 32'h0,        1, 32'h44332211, 0));

        repeat (2) @(posedge hclk);
        #1;
        check("reset_hreadyout", 32'(hreadyout), 32'd1);
        check("reset_hresp", 32'(hresp), 32'd0);
        check("reset_hrdata", hrdata, 32'd0);
        hreset = 1'b0;
        @(posedge hclk); #1;

        foreach (vecs[i]) begin
            xfer(vecs[i], rd, rf, rl, waits, to);
            check($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            check($sformatf("v%0d_resp_first", i), 32'(rf), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_resp_last", i), 32'(rl), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_waits", i), 32'(waits), vecs[i].exp_err ? 32'd1 : 32'(WS));
            if (vecs[i].chk_rd) begin
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            end
        end

        b2b("fwd_word", 3'd2, 32'h030, 32'hCAFEF00D, 32'h030, 32'hCAFEF00D);
        b2b("fwd_byte", 3'd0, 32'h031, 32'hFFFF5AFF, 32'h030, 32'hCAFE5A0D);

        // Address phases presented while another slave holds hready low are ignored
        stall = 1'b1;
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h010; hwrite = 1'b0; hsize = 3'd2;
        @(posedge hclk); #1;
        haddr = 32'h002;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; stall = 1'b0;
        check("stall_hreadyout", 32'(hreadyout), 32'd1);
        check("stall_hresp", 32'(hresp), 32'd0);
        check("stall_hrdata", hrdata, 32'hCAFE5A0D);
        repeat (3) @(posedge hclk);
        #1;
        check("stall_hrdata_later", hrdata, 32'hCAFE5A0D);
        check("stall_hresp_later", 32'(hresp), 32'd0);

        // Reset during the data phase of a write discards it
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h040; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h55555555; hreset = 1'b1;
        @(posedge hclk); #1;
        check("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_mid_hresp", 32'(hresp), 32'd0);
        check("rst_mid_hrdata", hrdata, 32'd0);
        hreset = 1'b0;
        @(posedge hclk); #1;
        xfer(mk(0, 3'd2, 32'h040, 32'h0, 1, 32'hAAAAAAAA, 0), rd, rf, rl, waits, to);
        check("rst_read_timeout", 32'(to), 32'd0);
        check("rst_read_rdata", rd, 32'hAAAAAAAA);
        check("rst_read_resp", 32'(rl), 32'd0);
        check("rst_read_waits", 32'(waits), 32'(WS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
